// File: rtl/minifloat_pkg.sv
// Shared minifloat types and constants for the decode and accumulate path.
package minifloat_pkg;
  localparam int MF_EXP_W = 4;
  localparam int MF_MAN_W = 3;
  localparam int MF_VAL_W = 18;

  typedef struct packed {
    logic [MF_EXP_W-1:0] exp;
    logic [MF_MAN_W-1:0] man;
  } mf_t;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } acc_state_t;
endpackage

// File: rtl/minifloat_decode.sv
// Combinational minifloat-to-integer decode: exp==0 is a plain mantissa, otherwise (8+man)<<(exp-1).
module minifloat_decode
  import minifloat_pkg::*;
(
  input  mf_t                 mf,
  output logic [MF_VAL_W-1:0] value
);

  always_comb begin
    if (mf.exp == '0) value = MF_VAL_W'(mf.man);
    else              value = MF_VAL_W'({1'b1, mf.man}) << (mf.exp - 4'd1);
  end

endmodule

// File: rtl/minifloat_accumulator.sv
// Frame accumulator for decoded minifloat samples, one sum per frame with valid/ready handshakes.
// Define MINIFLOAT_ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module minifloat_accumulator
  import minifloat_pkg::*;
#(
  parameter int ACC_W     = 24,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_exp,
  input  logic [2:0]       in_man,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  acc_state_t          state;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic                ovf;
  mf_t                 beat;
  logic [MF_VAL_W-1:0] value;
  logic                accept;
  logic                close;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [ACC_W:0]      add_res;

  // Returns {sticky overflow, new accumulator}.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [MF_VAL_W-1:0] v,
                                             input logic ovf_in);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(v);
`ifdef MINIFLOAT_ACC_SAT_EN
    if (s[ACC_W] | ovf_in) return {1'b1, {ACC_W{1'b1}}};
    else                   return {1'b0, s[ACC_W-1:0]};
`else
    return {ovf_in | s[ACC_W], s[ACC_W-1:0]};
`endif
  endfunction

  assign beat = {in_exp, in_man};

  minifloat_decode u_decode (
    .mf    (beat),
    .value (value)
  );

  assign in_ready = (state == ACC);
  assign accept   = in_valid & in_ready;
  assign cnt_nxt  = cnt + 1'b1;
  assign close    = in_last | (cnt_nxt == CNT_W'(FRAME_LEN));
  assign add_res  = acc_add(acc, value, ovf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc <= add_res[ACC_W-1:0];
            ovf <= add_res[ACC_W];
            cnt <= cnt_nxt;
            if (close) begin
              out_sum   <= add_res[ACC_W-1:0];
              out_count <= cnt_nxt;
              out_ovf   <= add_res[ACC_W];
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          // Result registers hold until the consumer takes them.
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_minifloat_accumulator.sv
// Directed bench for minifloat_accumulator with ACC_W=18, FRAME_LEN=4.
module tb_minifloat_accumulator;
  localparam int ACC_W     = 18;
  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
`ifdef MINIFLOAT_ACC_SAT_EN
  localparam logic [31:0] OVF_SUM = 32'd262143;
`else
  localparam logic [31:0] OVF_SUM = 32'd229376;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_exp;
  logic [2:0]       in_man;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  minifloat_accumulator #(.ACC_W(ACC_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_exp    (in_exp),
    .in_man    (in_man),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Presents one beat and returns 1 time unit after the edge that accepted it.
  task automatic send_beat(input logic [3:0] e, input logic [2:0] m, input logic last);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_exp   = e;
    in_man   = m;
    in_last  = last;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("beat_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_exp   = 4'd0;
    in_man   = 3'd0;
    in_last  = 1'b0;
  endtask

  task automatic take_result(input string tag, input logic [31:0] sum,
                             input logic [31:0] cnt, input logic [31:0] ovf);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(out_sum), sum);
    chk({tag, "_cnt"}, 32'(out_count), cnt);
    chk({tag, "_ovf"}, 32'(out_ovf), ovf);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_clr"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_exp    = 4'd0;
    in_man    = 3'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_cnt", 32'(out_count), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_beat(4'd0, 3'd5, 1'b1);  take_result("dec_e0m5", 32'd5, 32'd1, 32'd0);
    send_beat(4'd1, 3'd0, 1'b1);  take_result("dec_e1m0", 32'd8, 32'd1, 32'd0);
    send_beat(4'd4, 3'd3, 1'b1);  take_result("dec_e4m3", 32'd88, 32'd1, 32'd0);
    send_beat(4'd15, 3'd7, 1'b1); take_result("dec_e15m7", 32'd245760, 32'd1, 32'd0);

    send_beat(4'd0, 3'd5, 1'b0);
    send_beat(4'd1, 3'd0, 1'b0);
    send_beat(4'd4, 3'd3, 1'b1);
    take_result("mixed", 32'd101, 32'd3, 32'd0);

    for (int i = 0; i < FRAME_LEN; i++) send_beat(4'd2, 3'd1, 1'b0);
    take_result("auto", 32'd72, 32'd4, 32'd0);
    send_beat(4'd1, 3'd0, 1'b1);
    take_result("auto_next", 32'd8, 32'd1, 32'd0);

    // Backpressure while a new beat is already waiting upstream.
    send_beat(4'd0, 3'd5, 1'b1);
    in_valid = 1'b1;
    in_exp   = 4'd0;
    in_man   = 3'd3;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_vld", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(out_sum), 32'd5);
      chk("bp_cnt", 32'(out_count), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_hs_vld", 32'(out_valid), 32'd0);
    chk("bp_hs_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    take_result("bp_next", 32'd3, 32'd1, 32'd0);

    send_beat(4'd15, 3'd7, 1'b0);
    send_beat(4'd15, 3'd7, 1'b1);
    take_result("ovf", OVF_SUM, 32'd2, 32'd1);

    // out_sum still holds the overflow frame, so a cleared value proves the reset.
    send_beat(4'd0, 3'd5, 1'b0);
    send_beat(4'd0, 3'd5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_vld", 32'(out_valid), 32'd0);
    chk("mrst_sum", 32'(out_sum), 32'd0);
    chk("mrst_cnt", 32'(out_count), 32'd0);
    chk("mrst_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_beat(4'd1, 3'd0, 1'b1);
    take_result("mrst_next", 32'd8, 32'd1, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
